// File: rtl/mux8way_collector_if.sv
// rtl/mux8way_collector_if.sv - lane and output handshake bundle for the 8-way collector
//
// Purpose: groups the eight source lanes and the single collected output stream.
// Ports (signals):
//   in_valid  [7:0]        lane i has a word pending
//   in_data   [8*WIDTH-1:0] lane i word at bits [i*WIDTH +: WIDTH]
//   in_ready  [7:0]        lane i word accepted this cycle (at most one bit set)
//   out_valid              out_data/out_sel hold a word
//   out_data  [WIDTH-1:0]  collected word
//   out_sel   [2:0]        source lane of out_data
//   out_ready              downstream accepts the word this cycle
// Modports: master = sources plus sink (testbench side), slave = collector.
interface mux8way_collector_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux8way_collector.sv
// rtl/mux8way_collector.sv - round-robin collector of 8 valid/ready lanes into one tagged stream
//
// Purpose: picks one pending lane per cycle in fair round-robin order and loads its
// word, tagged with the lane index, into a one-entry output register.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux8way_collector_if.slave (lane inputs, in_ready, out_* stream)
module mux8way_collector #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mux8way_collector_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       sel_q;

    logic [WIDTH-1:0] lane_words [8];
    logic [2:0]       grant;
    logic [2:0]       scan_idx;
    logic             found;
    logic             can_load;
    logic             load;

    // Unpack the flat lane bus so the granted word is a simple array read.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_words[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin scan starting at ptr; 3-bit addition wraps lane 7 back to lane 0.
    always_comb begin
        grant    = 3'd0;
        found    = 1'b0;
        scan_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            scan_idx = ptr_q + 3'(k);
            if (!found && bus.in_valid[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    // can_load is true while in reset (register EMPTY), so rst_n gates load to keep
    // in_ready low for the whole reset period.
    always_comb begin
        can_load    = (state_q == EMPTY) || bus.out_ready;
        load        = rst_n && can_load && found;
        bus.in_ready = load ? (8'b1 << grant) : 8'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                // A consume with a same-cycle load keeps the register full.
                if (bus.out_ready && !load) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data and tag only change on a load, so a consumed word stays visible (with
    // out_valid low) until the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            sel_q  <= 3'd0;
            ptr_q  <= 3'd0;
        end else if (load) begin
            data_q <= lane_words[grant];
            sel_q  <= grant;
            ptr_q  <= grant + 3'd1;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_collector.sv
// tb/tb_mux8way_collector.sv - self-checking bench for mux8way_collector
module tb_mux8way_collector;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;

    mux8way_collector_if #(.WIDTH(WIDTH)) bus_if ();

    mux8way_collector #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: contents of the output register and the next lane in turn.
    bit          m_valid;
    int          m_data;
    int          m_sel;
    int          m_ptr;
    int          m_grant;

    typedef struct {
        logic [7:0] valid;
        logic [7:0] exp_ready;
        logic       exp_ov;
        int         exp_sel;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
        m_ptr   = 0;
        m_grant = -1;
    endtask

    // One clock: at the falling edge compare everything against the model, then
    // advance the model with the rising edge. Returns at rising edge + 1.
    task automatic step();
        int g;
        logic [7:0] er;
        logic [8*WIDTH-1:0] d;
        @(negedge clk);
        g = -1;
        if (rst_n && (!m_valid || bus_if.out_ready)) begin
            for (int k = 0; k < 8; k++) begin
                int l;
                l = (m_ptr + k) % 8;
                if (g < 0 && bus_if.in_valid[l]) g = l;
            end
        end
        er = (g >= 0) ? 8'(1 << g) : 8'h00;
        d  = bus_if.in_data;
        chk("in_ready", 32'(bus_if.in_ready), 32'(er));
        chk("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus_if.out_data), 32'(m_data));
        chk("out_sel", 32'(bus_if.out_sel), 32'(m_sel));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1;
            m_data  = int'(d[g*WIDTH +: WIDTH]);
            m_sel   = g;
            m_ptr   = (g + 1) % 8;
        end else if (m_valid && bus_if.out_ready) begin
            m_valid = 0;
        end
        m_grant = g;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] w);
        bus_if.in_data[i*WIDTH +: WIDTH] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];
    bit   lane_v [8];

    initial begin
        // ---------------- reset check ----------------
        rst_n = 1'b0;
        model_reset();
        bus_if.in_valid  = 8'hFF;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus_if.out_data), 32'd0);
        chk("rst_out_sel", 32'(bus_if.out_sel), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        @(posedge clk);
        #1;
        set_lane(0, 16'h1234);
        bus_if.out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("rel_out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("rel_out_data", 32'(bus_if.out_data), 32'h1234);
        chk("rel_out_sel", 32'(bus_if.out_sel), 32'd0);
        bus_if.in_valid = 8'h00;
        step();

        // ---------------- table: single-lane sweep then mixed masks ----------------
        do_reset();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) set_lane(i, 16'(16'hA0 + i));
        for (int s = 0; s < 8; s++) vecs.push_back('{8'(1 << s), 8'(1 << s), 1'b1, s});
        vecs.push_back('{8'h24, 8'h04, 1'b1, 2});   // ptr 0 -> lane 2
        vecs.push_back('{8'h24, 8'h20, 1'b1, 5});   // ptr 3 -> lane 5
        vecs.push_back('{8'h81, 8'h80, 1'b1, 7});   // ptr 6 -> lane 7
        vecs.push_back('{8'h81, 8'h01, 1'b1, 0});   // wrap: ptr 0 -> lane 0
        vecs.push_back('{8'h00, 8'h00, 1'b0, 0});   // nothing pending: drains
        foreach (vecs[v]) begin
            bus_if.in_valid = vecs[v].valid;
            #1;
            chk($sformatf("tbl%0d_ready", v), 32'(bus_if.in_ready), 32'(vecs[v].exp_ready));
            step();
            chk($sformatf("tbl%0d_ov", v), 32'(bus_if.out_valid), 32'(vecs[v].exp_ov));
            chk($sformatf("tbl%0d_sel", v), 32'(bus_if.out_sel), 32'(vecs[v].exp_sel));
            chk($sformatf("tbl%0d_data", v), 32'(bus_if.out_data), 32'(16'hA0 + vecs[v].exp_sel));
        end

        // ---------------- round robin under full load ----------------
        do_reset();
        for (int i = 0; i < 8; i++) set_lane(i, 16'(i));
        bus_if.in_valid  = 8'hFF;
        bus_if.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("rr%0d_valid", c), 32'(bus_if.out_valid), 32'd1);
            chk($sformatf("rr%0d_sel", c), 32'(bus_if.out_sel), 32'(c % 8));
        end
        bus_if.in_valid = 8'h00;
        step();

        // ---------------- backpressure ----------------
        do_reset();
        set_lane(2, 16'h2222);
        set_lane(5, 16'h5555);
        bus_if.in_valid  = 8'h24;
        bus_if.out_ready = 1'b1;
        step();
        chk("bp_load_sel", 32'(bus_if.out_sel), 32'd2);
        bus_if.in_valid  = 8'h20;
        bus_if.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), 32'(bus_if.in_ready), 32'd0);
            step();
            chk($sformatf("bp%0d_sel", c), 32'(bus_if.out_sel), 32'd2);
            chk($sformatf("bp%0d_data", c), 32'(bus_if.out_data), 32'h2222);
            chk($sformatf("bp%0d_valid", c), 32'(bus_if.out_valid), 32'd1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus_if.in_ready), 32'h20);
        step();
        chk("bp_release_sel", 32'(bus_if.out_sel), 32'd5);
        chk("bp_release_data", 32'(bus_if.out_data), 32'h5555);
        bus_if.in_valid = 8'h00;
        step();

        // ---------------- sparse lanes with pointer wrap ----------------
        do_reset();
        set_lane(1, 16'h0101);
        set_lane(6, 16'h0606);
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 8'h40;
        step();                       // lane 6 moves ptr to 7
        bus_if.in_valid = 8'h42;
        step();
        chk("wrap_first", 32'(bus_if.out_sel), 32'd1);
        step();
        chk("wrap_second", 32'(bus_if.out_sel), 32'd6);
        step();
        chk("wrap_third", 32'(bus_if.out_sel), 32'd1);
        bus_if.in_valid = 8'h00;
        step();

        // ---------------- asynchronous reset mid-operation ----------------
        do_reset();
        set_lane(3, 16'h3333);
        set_lane(4, 16'h4444);
        bus_if.in_valid  = 8'h08;
        bus_if.out_ready = 1'b0;
        step();
        chk("mid_full", 32'(bus_if.out_valid), 32'd1);
        bus_if.in_valid = 8'h10;
        #2;                           // rising edge + 3: well clear of any edge
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_async_valid", 32'(bus_if.out_valid), 32'd0);
        chk("mid_async_data", 32'(bus_if.out_data), 32'd0);
        chk("mid_async_ready", 32'(bus_if.in_ready), 32'd0);
        bus_if.out_ready = 1'b1;
        rst_n = 1'b1;
        step();
        chk("mid_after_sel", 32'(bus_if.out_sel), 32'd4);
        chk("mid_after_data", 32'(bus_if.out_data), 32'h4444);
        bus_if.in_valid = 8'h24;      // ptr should now be 5: lane 5 before lane 2
        step();
        chk("mid_ptr_next", 32'(bus_if.out_sel), 32'd5);
        bus_if.in_valid = 8'h00;
        step();

        // ---------------- randomized traffic ----------------
        do_reset();
        foreach (lane_v[i]) lane_v[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!lane_v[i] && ($urandom_range(0, 2) == 0)) begin
                    lane_v[i] = 1;
                    set_lane(i, 16'($urandom));
                end
                bus_if.in_valid[i] = lane_v[i];
            end
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (m_grant >= 0) lane_v[m_grant] = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
